sprite_line_fetcher: RTL and testbench

Per-scanline sequencer for the 8x8 sprite ROM. On each line-start pulse it scans the sprite attribute table and selects up to MAX_PER_LINE sprites that intersect the next scanline. For each selected sprite it drives the ROM address (sprite ID, orientation, line index) and captures the returned 8-pixel row. It then commits a double-buffered line descriptor to the pixel renderer, which keeps the single shared ROM off the per-pixel path.

---
 rtl/sprite_pkg.sv | 27 ++
 rtl/sprite_line_hit.sv | 21 ++
 rtl/sprite_line_fetcher.sv | 171 +++++++++++++++++
 tb/tb_sprite_line_fetcher.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared constants for the 8x8 sprite ROM: orientation codes, tile geometry
// and the sprite ID map.
package sprite_pkg;

  typedef enum logic [1:0] {
    ORIENT_UP    = 2'd0,
    ORIENT_RIGHT = 2'd1,
    ORIENT_DOWN  = 2'd2,
    ORIENT_LEFT  = 2'd3
  } orient_t;

  localparam int SPRITE_H = 8;
  localparam int SPRITE_W = 8;

  localparam logic [3:0] BLANK_SPRITE_ID = 4'hF;

  localparam logic [3:0] HEART        = 4'd0;
  localparam logic [3:0] COIN         = 4'd1;
  localparam logic [3:0] KEY          = 4'd2;
  localparam logic [3:0] DOOR         = 4'd3;
  localparam logic [3:0] WOLF_1       = 4'd4;
  localparam logic [3:0] WOLF_2       = 4'd5;
  localparam logic [3:0] GRASS        = 4'd6;
  localparam logic [3:0] SHEEP_IDLE_1 = 4'd7;
  localparam logic [3:0] SHEEP_IDLE_2 = 4'd8;

endpackage

// File: rtl/sprite_line_hit.sv
// Vertical intersection test of one attribute entry against a scanline.
// The subtraction carries an extra bit so sprites near the bottom clip instead of wrapping.
module sprite_line_hit
  import sprite_pkg::*;
#(
  parameter int Y_W = 10
) (
  input  logic           en,
  input  logic [Y_W-1:0] line_y,
  input  logic [Y_W-1:0] top_y,
  output logic           hit,
  output logic [2:0]     line_index
);

  logic [Y_W:0] diff;

  assign diff       = {1'b0, line_y} - {1'b0, top_y};
  assign hit        = en && !diff[Y_W] && (diff[Y_W-1:0] < Y_W'(SPRITE_H));
  assign line_index = diff[2:0];

endmodule

// File: rtl/sprite_line_fetcher.sv
// Per-scanline sprite selector and ROM row fetcher with a double-buffered line descriptor.
// Optional SPRITE_FETCH_DROP_COUNT_EN adds a saturating drop_count output.
module sprite_line_fetcher
  import sprite_pkg::*;
#(
  parameter int NUM_SPRITES  = 8,
  parameter int MAX_PER_LINE = 4,
  parameter int X_W          = 10,
  parameter int Y_W          = 10
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      line_start,
  input  logic [Y_W-1:0]            next_y,
  input  logic [NUM_SPRITES-1:0]    sprite_en,
  input  logic [NUM_SPRITES*X_W-1:0] sprite_x,
  input  logic [NUM_SPRITES*Y_W-1:0] sprite_y,
  input  logic [NUM_SPRITES*4-1:0]  sprite_id,
  input  logic [NUM_SPRITES*2-1:0]  sprite_orient,
  output logic [3:0]                rom_sprite_id,
  output logic [1:0]                rom_orientation,
  output logic [2:0]                rom_line_index,
  input  logic [7:0]                rom_data,
  output logic [MAX_PER_LINE*8-1:0] line_pixels,
  output logic [MAX_PER_LINE*X_W-1:0] line_x,
  output logic [MAX_PER_LINE-1:0]   line_valid,
  output logic                      busy,
  output logic                      done,
  output logic                      overflow
`ifdef SPRITE_FETCH_DROP_COUNT_EN
  ,
  output logic [3:0]                drop_count
`endif
);

  localparam int IDX_W  = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
  localparam int SLOT_W = $clog2(MAX_PER_LINE + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SCAN   = 2'd1;
  localparam logic [1:0] ST_FETCH  = 2'd2;
  localparam logic [1:0] ST_COMMIT = 2'd3;

  logic [1:0]                state;
  logic [IDX_W-1:0]          idx;
  logic [SLOT_W-1:0]         slot;
  logic [Y_W-1:0]            y_q;
  logic [MAX_PER_LINE*8-1:0] work_pixels;
  logic [MAX_PER_LINE*X_W-1:0] work_x;
  logic [MAX_PER_LINE-1:0]   work_valid;
  logic                      work_ovf;
`ifdef SPRITE_FETCH_DROP_COUNT_EN
  logic [3:0]                work_drops;
`endif

  logic           sel_en;
  logic [X_W-1:0] sel_x;
  logic [Y_W-1:0] sel_y;
  logic [3:0]     sel_id;
  logic [1:0]     sel_orient;
  logic           hit;
  logic [2:0]     hit_line;
  logic           last;
  logic           slot_free;

  // The table entry under the scan pointer drives the single shared hit comparator.
  always_comb begin
    sel_en     = sprite_en[idx];
    sel_x      = sprite_x[int'(idx)*X_W +: X_W];
    sel_y      = sprite_y[int'(idx)*Y_W +: Y_W];
    sel_id     = sprite_id[int'(idx)*4 +: 4];
    sel_orient = sprite_orient[int'(idx)*2 +: 2];
  end

  sprite_line_hit #(.Y_W(Y_W)) u_hit (
    .en         (sel_en),
    .line_y     (y_q),
    .top_y      (sel_y),
    .hit        (hit),
    .line_index (hit_line)
  );

  assign last      = (idx == IDX_W'(NUM_SPRITES - 1));
  assign slot_free = (slot < SLOT_W'(MAX_PER_LINE));
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_COMMIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_IDLE;
      idx             <= '0;
      slot            <= '0;
      y_q             <= '0;
      work_pixels     <= '0;
      work_x          <= '0;
      work_valid      <= '0;
      work_ovf        <= 1'b0;
      rom_sprite_id   <= BLANK_SPRITE_ID;
      rom_orientation <= '0;
      rom_line_index  <= '0;
      line_pixels     <= '0;
      line_x          <= '0;
      line_valid      <= '0;
      overflow        <= 1'b0;
`ifdef SPRITE_FETCH_DROP_COUNT_EN
      work_drops      <= '0;
      drop_count      <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (line_start) begin
            y_q         <= next_y;
            idx         <= '0;
            slot        <= '0;
            work_pixels <= '0;
            work_x      <= '0;
            work_valid  <= '0;
            work_ovf    <= 1'b0;
`ifdef SPRITE_FETCH_DROP_COUNT_EN
            work_drops  <= '0;
`endif
            state       <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (hit && slot_free) begin
            rom_sprite_id   <= sel_id;
            rom_orientation <= sel_orient;
            rom_line_index  <= hit_line;
            state           <= ST_FETCH;
          end else begin
            if (hit) begin
              work_ovf <= 1'b1;
`ifdef SPRITE_FETCH_DROP_COUNT_EN
              if (work_drops != 4'hF) work_drops <= work_drops + 4'd1;
`endif
            end
            if (last) state <= ST_COMMIT;
            else      idx   <= idx + 1'b1;
          end
        end
        ST_FETCH: begin
          // The ROM answers combinationally to the address registered during SCAN.
          work_pixels[int'(slot)*8 +: 8]     <= rom_data;
          work_x[int'(slot)*X_W +: X_W]      <= sel_x;
          work_valid[slot]                   <= 1'b1;
          slot                               <= slot + 1'b1;
          if (last) begin
            state <= ST_COMMIT;
          end else begin
            idx   <= idx + 1'b1;
            state <= ST_SCAN;
          end
        end
        default: begin
          line_pixels   <= work_pixels;
          line_x        <= work_x;
          line_valid    <= work_valid;
          overflow      <= work_ovf;
`ifdef SPRITE_FETCH_DROP_COUNT_EN
          drop_count    <= work_drops;
`endif
          rom_sprite_id <= BLANK_SPRITE_ID;
          state         <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_line_fetcher.sv
// Directed bench for sprite_line_fetcher with a small behavioural sprite ROM.
// Covers single hits, slot overflow, vertical clipping, busy/commit line_start handling and mid-fetch reset.
module tb_sprite_line_fetcher;
  import sprite_pkg::*;

  localparam int NS = 8;
  localparam int MP = 4;
  localparam int XW = 10;
  localparam int YW = 10;

  logic            clk = 1'b0;
  logic            reset;
  logic            line_start;
  logic [YW-1:0]   next_y;
  logic [NS-1:0]   sprite_en;
  logic [NS*XW-1:0] sprite_x;
  logic [NS*YW-1:0] sprite_y;
  logic [NS*4-1:0] sprite_id;
  logic [NS*2-1:0] sprite_orient;
  logic [3:0]      rom_sprite_id;
  logic [1:0]      rom_orientation;
  logic [2:0]      rom_line_index;
  logic [7:0]      rom_data;
  logic [MP*8-1:0] line_pixels;
  logic [MP*XW-1:0] line_x;
  logic [MP-1:0]   line_valid;
  logic            busy;
  logic            done;
  logic            overflow;
`ifdef SPRITE_FETCH_DROP_COUNT_EN
  logic [3:0]      drop_count;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  sprite_line_fetcher #(
    .NUM_SPRITES (NS),
    .MAX_PER_LINE(MP),
    .X_W         (XW),
    .Y_W         (YW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .line_start     (line_start),
    .next_y         (next_y),
    .sprite_en      (sprite_en),
    .sprite_x       (sprite_x),
    .sprite_y       (sprite_y),
    .sprite_id      (sprite_id),
    .sprite_orient  (sprite_orient),
    .rom_sprite_id  (rom_sprite_id),
    .rom_orientation(rom_orientation),
    .rom_line_index (rom_line_index),
    .rom_data       (rom_data),
    .line_pixels    (line_pixels),
    .line_x         (line_x),
    .line_valid     (line_valid),
    .busy           (busy),
    .done           (done),
    .overflow       (overflow)
`ifdef SPRITE_FETCH_DROP_COUNT_EN
    ,
    .drop_count     (drop_count)
`endif
  );

  always #5 clk = ~clk;

  // Stand-in ROM: two known rows, everything else an address-derived pattern.
  function automatic logic [7:0] rom_model(input logic [3:0] id, input logic [1:0] o,
                                           input logic [2:0] l);
    if (id == HEART && o == ORIENT_UP && l == 3'd1) return 8'b10011001;
    if (id == SHEEP_IDLE_1 && o == ORIENT_DOWN && l == 3'd0) return 8'b11100011;
    return {id, 1'b0, l} ^ {o, 6'b0};
  endfunction

  always_comb rom_data = rom_model(rom_sprite_id, rom_orientation, rom_line_index);

  task automatic check_output(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_table();
    sprite_en     = '0;
    sprite_x      = '0;
    sprite_y      = '0;
    sprite_id     = '0;
    sprite_orient = '0;
  endtask

  task automatic set_sprite(input int i, input logic [XW-1:0] x, input logic [YW-1:0] y,
                            input logic [3:0] id, input logic [1:0] o);
    sprite_en[i]              = 1'b1;
    sprite_x[i*XW +: XW]      = x;
    sprite_y[i*YW +: YW]      = y;
    sprite_id[i*4 +: 4]       = id;
    sprite_orient[i*2 +: 2]   = o;
  endtask

  // line_start is high during cycle 0; returns observing cycle 1.
  task automatic apply_stimulus(input logic [YW-1:0] y);
    next_y     = y;
    line_start = 1'b1;
    cyc        = 0;
    step();
    line_start = 1'b0;
  endtask

  // Waits for done, checks its cycle, then moves into the following IDLE cycle.
  task automatic wait_done(input string tag, input int exp_cycle, input bit poke);
    int guard = 0;
    while (!done && guard < 60) begin
      step();
      guard++;
    end
    check_output({tag, "_done_seen"}, 64'(done), 64'd1);
    check_output({tag, "_done_cycle"}, 64'(cyc), 64'(exp_cycle));
    if (poke) line_start = 1'b1;
    step();
    line_start = 1'b0;
    check_output({tag, "_busy_after"}, 64'(busy), 64'd0);
    check_output({tag, "_rom_blank"}, 64'(rom_sprite_id), 64'(BLANK_SPRITE_ID));
  endtask

  initial begin
    int done_count;
    reset      = 1'b1;
    line_start = 1'b0;
    next_y     = '0;
    clear_table();
    step();
    step();
    check_output("rst_busy", 64'(busy), 64'd0);
    check_output("rst_done", 64'(done), 64'd0);
    check_output("rst_rom_id", 64'(rom_sprite_id), 64'hF);
    check_output("rst_valid", 64'(line_valid), 64'd0);
    check_output("rst_ovf", 64'(overflow), 64'd0);
    reset = 1'b0;
    step();

    // Heart at y=100, x=37, line 101 -> row 1 of the UP tile
    set_sprite(0, 10'd37, 10'd100, HEART, ORIENT_UP);
    apply_stimulus(10'd101);
    check_output("heart_busy", 64'(busy), 64'd1);
    check_output("heart_rom_c1", 64'(rom_sprite_id), 64'hF);
    step();
    check_output("heart_rom_id", 64'(rom_sprite_id), 64'd0);
    check_output("heart_rom_or", 64'(rom_orientation), 64'd0);
    check_output("heart_rom_li", 64'(rom_line_index), 64'd1);
    wait_done("heart", 10, 1'b0);
    check_output("heart_pix", 64'(line_pixels), 64'h0000_0099);
    check_output("heart_x", 64'(line_x), {24'd0, 30'd0, 10'd37});
    check_output("heart_valid", 64'(line_valid), 64'b0001);
    check_output("heart_ovf", 64'(overflow), 64'd0);

    // Sheep at entry 3; line_start in the IDLE cycle right after commit is accepted
    clear_table();
    set_sprite(3, 10'd300, 10'd200, SHEEP_IDLE_1, ORIENT_DOWN);
    apply_stimulus(10'd200);
    check_output("sheep_busy", 64'(busy), 64'd1);
    wait_done("sheep", 10, 1'b0);
    check_output("sheep_pix", 64'(line_pixels), 64'h0000_00E3);
    check_output("sheep_x", 64'(line_x), {24'd0, 30'd0, 10'd300});
    check_output("sheep_valid", 64'(line_valid), 64'b0001);

    // One line above the sprite: no hit
    clear_table();
    set_sprite(0, 10'd5, 10'd100, COIN, ORIENT_UP);
    apply_stimulus(10'd99);
    wait_done("above", 9, 1'b0);
    check_output("above_valid", 64'(line_valid), 64'd0);
    check_output("above_pix", 64'(line_pixels), 64'd0);

    // Bottom clip must not wrap; line_start during done is ignored
    clear_table();
    set_sprite(1, 10'd5, 10'd1020, KEY, ORIENT_UP);
    apply_stimulus(10'd2);
    wait_done("nowrap", 9, 1'b1);
    check_output("nowrap_valid", 64'(line_valid), 64'd0);
    check_output("nowrap_ovf", 64'(overflow), 64'd0);
    step();
    check_output("commit_ls_ignored", 64'(busy), 64'd0);

    // Six hits on row 7, only four slots
    clear_table();
    for (int i = 0; i < 6; i++)
      set_sprite(i, 10'(10 * i + 3), 10'd50, 4'(i + 1), 2'(i));
    apply_stimulus(10'd57);
    wait_done("six", 13, 1'b0);
    check_output("six_pix", 64'(line_pixels), 64'h87B7_6717);
    check_output("six_x", 64'(line_x), {24'd0, 10'd33, 10'd23, 10'd13, 10'd3});
    check_output("six_valid", 64'(line_valid), 64'b1111);
    check_output("six_ovf", 64'(overflow), 64'd1);
`ifdef SPRITE_FETCH_DROP_COUNT_EN
    check_output("six_drops", 64'(drop_count), 64'd2);
`endif
    step();
    step();
    step();
    check_output("six_hold_pix", 64'(line_pixels), 64'h87B7_6717);
    check_output("six_hold_valid", 64'(line_valid), 64'b1111);

    // Reset in cycle 4 of a fetch; a second line_start in cycle 3 is ignored
    apply_stimulus(10'd57);
    step();
    step();
    line_start = 1'b1;
    step();
    line_start = 1'b0;
    reset      = 1'b1;
    step();
    reset = 1'b0;
    check_output("abort_busy", 64'(busy), 64'd0);
    check_output("abort_done", 64'(done), 64'd0);
    check_output("abort_valid", 64'(line_valid), 64'd0);
    check_output("abort_pix", 64'(line_pixels), 64'd0);
    check_output("abort_x", 64'(line_x), 64'd0);
    check_output("abort_ovf", 64'(overflow), 64'd0);
    check_output("abort_rom_id", 64'(rom_sprite_id), 64'hF);
    check_output("abort_rom_li", 64'(rom_line_index), 64'd0);
`ifdef SPRITE_FETCH_DROP_COUNT_EN
    check_output("abort_drops", 64'(drop_count), 64'd0);
`endif
    done_count = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) done_count++;
      step();
    end
    check_output("abort_no_done", 64'(done_count), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
